// File: rtl/control_pkg.sv
// Shared types and decode constants for the multicycle MIPS control FSM.
package control_pkg;

    // State encodings are visible on State_out, so the values are fixed.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_ADDI_EXEC = 4'd4,
        S_ADDI_WB   = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_EXCEPT    = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_INC  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_COMP = 3'd7
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    // True for the R-type function codes this controller executes.
    function automatic logic is_known_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_XOR);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for memory states: counts cycles spent in the current
// memory state and flags the final one (count == MEM_WAIT).
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic last_o
);
    localparam logic [3:0] LAST_COUNT = 4'(MEM_WAIT);

    logic [3:0] count_q, count_d;

    // Clear takes priority so a new memory state always starts at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (enable_i) begin
            count_d = count_q + 4'd1;
        end
    end

    // Counter register, zeroed asynchronously with the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (add/sub/and/xor, addi, lw, sw, beq, bne, j).
// Memory states last MEM_WAIT+1 cycles. Define CTRL_EXCEPTION_EN to trap
// undefined instructions through the EXCEPT state; otherwise they act as NOPs.
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemReadWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       AluSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ABWrite,
    output logic       AluOutWrite,
    output logic       MDRWrite,
    output logic       EPCWrite,
    output logic [1:0] PCSource,
    output logic [1:0] AluSrcB,
    output logic [2:0] ALUOpOut,
    output logic [5:0] State_out
);
    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    mem_last;
    logic    in_mem_state;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);

    // Any state change restarts the count, so each memory state starts at 0.
    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk_i    (clock),
        .rst_ni   (reset),
        .clear_i  (state_d != state_q),
        .enable_i (in_mem_state),
        .last_o   (mem_last)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        state_d      = state_q;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        BranchNe     = 1'b0;
        IorD         = 1'b0;
        MemReadWrite = 1'b0;
        MemtoReg     = 1'b0;
        IRWrite      = 1'b0;
        AluSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ABWrite      = 1'b0;
        AluOutWrite  = 1'b0;
        MDRWrite     = 1'b0;
        EPCWrite     = 1'b0;
        PCSource     = 2'd0;
        AluSrcB      = 2'd0;
        alu_op       = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                AluSrcB = 2'd1;
                if (mem_last) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                AluSrcB     = 2'd3;
                AluOutWrite = 1'b1;
                ABWrite     = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (is_known_funct(funct)) begin
                            state_d = S_R_EXEC;
                        end else begin
`ifdef CTRL_EXCEPTION_EN
                            state_d = S_EXCEPT;
`else
                            state_d = S_FETCH;
`endif
                        end
                    end
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin
`ifdef CTRL_EXCEPTION_EN
                        state_d = S_EXCEPT;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_R_EXEC: begin
                AluSrcA     = 1'b1;
                AluOutWrite = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_XOR:  alu_op = ALU_XOR;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EXEC: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'd2;
                AluOutWrite = 1'b1;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                AluSrcA     = 1'b1;
                AluSrcB     = 2'd2;
                AluOutWrite = 1'b1;
                state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                IorD = 1'b1;
                if (mem_last) begin
                    MDRWrite = 1'b1;
                    state_d  = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                IorD         = 1'b1;
                MemReadWrite = 1'b1;
                if (mem_last) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                AluSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                BranchNe    = (opcode == OP_BNE);
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                alu_op   = ALU_LOAD;
                state_d  = S_FETCH;
            end
`ifdef CTRL_EXCEPTION_EN
            // PC already points past the faulting word; PC-4 goes to EPC.
            S_EXCEPT: begin
                AluSrcB  = 2'd1;
                alu_op   = ALU_SUB;
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'd3;
                state_d  = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // While reset is held no register or memory may be written.
        if (!reset) begin
            PCWrite      = 1'b0;
            PCWriteCond  = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            ABWrite      = 1'b0;
            AluOutWrite  = 1'b0;
            MDRWrite     = 1'b0;
            EPCWrite     = 1'b0;
            MemReadWrite = 1'b0;
        end
    end

    assign ALUOpOut  = alu_op;
    assign State_out = {2'b00, state_q};

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Four instances run side by side with
// MEM_WAIT = 0,1,2,3 (instance index == MEM_WAIT) sharing clock, reset and IR.
module tb_multicycle_control;
    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;

    logic [3:0] pc_write, pc_write_cond, branch_ne, iord, mrw, mem_to_reg;
    logic [3:0] ir_write, alu_src_a, reg_write, reg_dst, ab_write;
    logic [3:0] alu_out_write, mdr_write, epc_write;
    logic [1:0] pc_source [4];
    logic [1:0] alu_src_b [4];
    logic [2:0] alu_op    [4];
    logic [5:0] st        [4];

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        multicycle_control #(.MEM_WAIT(g)) dut (
            .clock        (clk),
            .reset        (rst_n),
            .opcode       (opcode),
            .funct        (funct),
            .PCWrite      (pc_write[g]),
            .PCWriteCond  (pc_write_cond[g]),
            .BranchNe     (branch_ne[g]),
            .IorD         (iord[g]),
            .MemReadWrite (mrw[g]),
            .MemtoReg     (mem_to_reg[g]),
            .IRWrite      (ir_write[g]),
            .AluSrcA      (alu_src_a[g]),
            .RegWrite     (reg_write[g]),
            .RegDst       (reg_dst[g]),
            .ABWrite      (ab_write[g]),
            .AluOutWrite  (alu_out_write[g]),
            .MDRWrite     (mdr_write[g]),
            .EPCWrite     (epc_write[g]),
            .PCSource     (pc_source[g]),
            .AluSrcB      (alu_src_b[g]),
            .ALUOpOut     (alu_op[g]),
            .State_out    (st[g])
        );
    end

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after an edge, in cycle 1 after reset release.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        opcode = 6'h2B;
        funct  = 6'h00;
        do_reset();
        for (int k = 1; k < 7; k++) step();
        n_cmp++;
        if (st[2] !== 6'd9 || mrw[2] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_state: state %0d mrw %0b, required 9 and 1", st[2], mrw[2]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mrw[2] !== 1'b0 || st[2] !== 6'd0) begin
            n_err++;
            $display("FAIL reset_async: mrw %0b state %0d, required 0 and 0", mrw[2], st[2]);
        end
        n_cmp++;
        if (ir_write[0] !== 1'b0 || pc_write[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gate_w0: irw %0b pcw %0b, required 0 0", ir_write[0], pc_write[0]);
        end
        n_cmp++;
        if ((pc_write | pc_write_cond | ir_write | reg_write | ab_write | alu_out_write |
             mdr_write | epc_write | mrw) !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_enables: some write enable high during reset");
        end
        n_cmp++;
        if (alu_src_b[2] !== 2'd1 || iord[2] !== 1'b0 || alu_op[2] !== 3'd1) begin
            n_err++;
            $display("FAIL reset_selects: srcb %0d iord %0b aluop %0d, required 1 0 1",
                     alu_src_b[2], iord[2], alu_op[2]);
        end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            e = (k == 3) ? 6'd1 : 6'd0;
            n_cmp++;
            if (ir_write[2] !== e[0] || pc_write[2] !== e[0]) begin
                n_err++;
                $display("FAIL reset_first_fetch cyc %0d: irw %0b pcw %0b, required %0b",
                         k, ir_write[2], pc_write[2], e[0]);
            end
            step();
        end
    endtask

    task automatic test_add();
        logic [5:0] e;
        opcode = 6'h00;
        funct  = 6'h20;
        do_reset();
        exp_q = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
        for (int k = 1; k <= 7; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (st[2] !== e) begin
                n_err++;
                $display("FAIL add_state cyc %0d: got %0d, required %0d", k, st[2], e);
            end
            n_cmp++;
            if (reg_write[2] !== (e == 6'd3) || reg_dst[2] !== (e == 6'd3)) begin
                n_err++;
                $display("FAIL add_regwrite cyc %0d: rw %0b rd %0b, required %0b",
                         k, reg_write[2], reg_dst[2], (e == 6'd3));
            end
            if (e == 6'd2) begin
                n_cmp++;
                if (alu_op[2] !== 3'd1) begin
                    n_err++;
                    $display("FAIL add_aluop: got %0d, required 1", alu_op[2]);
                end
            end
            if (k < 7) step();
        end
    endtask

    task automatic test_rtype_ops();
        logic [5:0] fn_tab [3] = '{6'h22, 6'h24, 6'h26};
        logic [2:0] op_tab [3] = '{3'd2, 3'd3, 3'd6};
        for (int i = 0; i < 3; i++) begin
            opcode = 6'h00;
            funct  = fn_tab[i];
            do_reset();
            step();
            step();
            n_cmp++;
            if (st[0] !== 6'd2 || alu_op[0] !== op_tab[i]) begin
                n_err++;
                $display("FAIL rtype_aluop funct %0h: state %0d op %0d, required 2 and %0d",
                         fn_tab[i], st[0], alu_op[0], op_tab[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [5:0] e;
        opcode = 6'h08;
        funct  = 6'h00;
        do_reset();
        exp_q = '{6'd0, 6'd0, 6'd1, 6'd4, 6'd5, 6'd0};
        for (int k = 1; k <= 6; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (st[1] !== e) begin
                n_err++;
                $display("FAIL addi_state cyc %0d: got %0d, required %0d", k, st[1], e);
            end
            if (e == 6'd4) begin
                n_cmp++;
                if (alu_src_b[1] !== 2'd2 || alu_src_a[1] !== 1'b1 || alu_out_write[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL addi_exec: srcb %0d srca %0b aow %0b, required 2 1 1",
                             alu_src_b[1], alu_src_a[1], alu_out_write[1]);
                end
            end
            if (e == 6'd5) begin
                n_cmp++;
                if (reg_write[1] !== 1'b1 || reg_dst[1] !== 1'b0 || mem_to_reg[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL addi_wb: rw %0b rd %0b m2r %0b, required 1 0 0",
                             reg_write[1], reg_dst[1], mem_to_reg[1]);
                end
            end
            if (k < 6) step();
        end
    endtask

    task automatic test_lw();
        logic [5:0] e;
        opcode = 6'h23;
        funct  = 6'h00;
        do_reset();
        exp_q = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd6, 6'd7, 6'd7, 6'd7, 6'd7, 6'd8, 6'd0};
        for (int k = 1; k <= 12; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (st[3] !== e) begin
                n_err++;
                $display("FAIL lw_state cyc %0d: got %0d, required %0d", k, st[3], e);
            end
            n_cmp++;
            if (mdr_write[3] !== (k == 10) || iord[3] !== (e == 6'd7)) begin
                n_err++;
                $display("FAIL lw_mdr cyc %0d: mdrw %0b iord %0b, required %0b %0b",
                         k, mdr_write[3], iord[3], (k == 10), (e == 6'd7));
            end
            n_cmp++;
            if (mem_to_reg[3] !== (e == 6'd8) || reg_write[3] !== (e == 6'd8) || mrw[3] !== 1'b0) begin
                n_err++;
                $display("FAIL lw_wb cyc %0d: m2r %0b rw %0b mrw %0b", k, mem_to_reg[3],
                         reg_write[3], mrw[3]);
            end
            if (k < 12) step();
        end
    endtask

    task automatic test_branch();
        logic [5:0] op_tab [2] = '{6'h05, 6'h04};
        for (int i = 0; i < 2; i++) begin
            opcode = op_tab[i];
            funct  = 6'h00;
            do_reset();
            step();
            step();
            n_cmp++;
            if (st[0] !== 6'd10 || pc_write_cond[0] !== 1'b1 || pc_source[0] !== 2'd1 ||
                alu_op[0] !== 3'd2 || pc_write[0] !== 1'b0) begin
                n_err++;
                $display("FAIL branch_ctrl op %0h: st %0d pwc %0b src %0d op %0d pcw %0b, required 10 1 1 2 0",
                         op_tab[i], st[0], pc_write_cond[0], pc_source[0], alu_op[0], pc_write[0]);
            end
            n_cmp++;
            if (branch_ne[0] !== (i == 0)) begin
                n_err++;
                $display("FAIL branch_ne op %0h: got %0b, required %0b", op_tab[i], branch_ne[0], (i == 0));
            end
            step();
            n_cmp++;
            if (st[0] !== 6'd0) begin
                n_err++;
                $display("FAIL branch_return op %0h: state %0d, required 0", op_tab[i], st[0]);
            end
        end
    endtask

    task automatic test_undef();
        logic [5:0] op_tab [2] = '{6'h3F, 6'h00};
        logic [5:0] fn_tab [2] = '{6'h00, 6'h21};
        int epc_seen;
        for (int i = 0; i < 2; i++) begin
            opcode = op_tab[i];
            funct  = fn_tab[i];
            do_reset();
            epc_seen = 0;
`ifdef CTRL_EXCEPTION_EN
            exp_q = '{6'd0, 6'd0, 6'd1, 6'd12, 6'd0};
`else
            exp_q = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd0};
`endif
            for (int k = 1; k <= 5; k++) begin
                if (epc_write[1] === 1'b1) epc_seen++;
                n_cmp++;
                if (st[1] !== exp_q[k-1]) begin
                    n_err++;
                    $display("FAIL undef_state op %0h cyc %0d: got %0d, required %0d",
                             op_tab[i], k, st[1], exp_q[k-1]);
                end
                if (st[1] == 6'd12) begin
                    n_cmp++;
                    if (pc_source[1] !== 2'd3 || pc_write[1] !== 1'b1 || alu_op[1] !== 3'd2 ||
                        alu_src_b[1] !== 2'd1) begin
                        n_err++;
                        $display("FAIL except_ctrl: src %0d pcw %0b op %0d srcb %0d, required 3 1 2 1",
                                 pc_source[1], pc_write[1], alu_op[1], alu_src_b[1]);
                    end
                end
                if (k < 5) step();
            end
            n_cmp++;
`ifdef CTRL_EXCEPTION_EN
            if (epc_seen != 1) begin
`else
            if (epc_seen != 0) begin
`endif
                n_err++;
                $display("FAIL undef_epc op %0h: EPCWrite high %0d cycles", op_tab[i], epc_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        int mrw_cnt;
        int iord_cnt;
        opcode = 6'h02;
        funct  = 6'h00;
        do_reset();
        mrw_cnt  = 0;
        iord_cnt = 0;
        exp_q = '{6'd0, 6'd0, 6'd1, 6'd11, 6'd0, 6'd0, 6'd1, 6'd6, 6'd9, 6'd9, 6'd0};
        for (int k = 1; k <= 11; k++) begin
            e = exp_q.pop_front();
            if (k == 5) opcode = 6'h2B;
            n_cmp++;
            if (st[1] !== e) begin
                n_err++;
                $display("FAIL b2b_state cyc %0d: got %0d, required %0d", k, st[1], e);
            end
            if (e == 6'd11) begin
                n_cmp++;
                if (pc_source[1] !== 2'd2 || pc_write[1] !== 1'b1 || alu_op[1] !== 3'd0) begin
                    n_err++;
                    $display("FAIL jump_ctrl: src %0d pcw %0b op %0d, required 2 1 0",
                             pc_source[1], pc_write[1], alu_op[1]);
                end
            end
            if (k >= 5) begin
                if (mrw[1] === 1'b1) mrw_cnt++;
                if (iord[1] === 1'b1) iord_cnt++;
            end
            if (k < 11) step();
        end
        n_cmp++;
        if (mrw_cnt != 2 || iord_cnt != 2) begin
            n_err++;
            $display("FAIL sw_write_len: mrw %0d iord %0d cycles, required 2 2", mrw_cnt, iord_cnt);
        end
    endtask

    // Test sequence and final report
    initial begin
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        #2;
        test_reset();
        test_add();
        test_rtype_ops();
        test_addi();
        test_lw();
        test_branch();
        test_undef();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised successor to the team's multicycle MIPS control FSM. It drives every datapath enable and mux select for a full instruction subset: R-type add/sub/and/xor, addi, lw, sw, beq, bne and j. Memory latency is a parameter, replacing the hard-wired fetch wait states. Optional undefined-instruction trapping is available. The block sits between the instruction register (opcode/funct) and the datapath; all outputs are decoded combinationally from the registered state.

## Interface
- MEM_WAIT, 2, memory wait cycles per access (0..15); each memory state lasts MEM_WAIT+1 cycles
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if (Zero XOR BranchNe)
- BranchNe  out  1  1 = bne polarity
- IorD  out  1  0 = PC address, 1 = AluOut address
- MemReadWrite  out  1  0 = read, 1 = write
- MemtoReg  out  1  1 = MDR to register file
- IRWrite  out  1  IR load
- AluSrcA  out  1  0 = PC, 1 = A
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- ABWrite  out  1  A and B register load
- AluOutWrite  out  1  AluOut load
- MDRWrite  out  1  MDR load
- EPCWrite  out  1  EPC load
- PCSource  out  2  0 = ALU, 1 = AluOut, 2 = jump target, 3 = exception vector
- AluSrcB  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- ALUOpOut  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7
- State_out  out  6  current state encoding

## Operation
- Unlisted outputs are 0 in every state; no X outputs.
- Defaults: ALUOp=ADD, PCSource=0, AluSrcB=0.
- States, with State_out values:
  - FETCH(0): IorD=0, read; AluSrcA=0, AluSrcB=1. Last cycle only: IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE(1): AluSrcA=0, AluSrcB=3, AluOutWrite=1, ABWrite=1. Dispatch on opcode:
    - 0x00 with funct 0x20/0x22/0x24/0x26 → R_EXEC
    - 0x08 → ADDI_EXEC
    - 0x23/0x2B → MEM_ADDR
    - 0x04/0x05 → BRANCH
    - 0x02 → JUMP
    - anything else → undefined instruction
  - R_EXEC(2): AluSrcA=1, AluSrcB=0, AluOutWrite=1. ALUOp: 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x26 → XOR. Next: R_WB.
  - R_WB(3): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - ADDI_EXEC(4): AluSrcA=1, AluSrcB=2, AluOutWrite=1. Next: ADDI_WB.
  - ADDI_WB(5): RegDst=0, RegWrite=1. Next: FETCH.
  - MEM_ADDR(6): AluSrcA=1, AluSrcB=2, AluOutWrite=1. Next: MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ(7): IorD=1, read; MDRWrite=1 on last cycle. Next: MEM_WB.
  - MEM_WB(8): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEM_WRITE(9): IorD=1, MemReadWrite=1 for all MEM_WAIT+1 cycles. Next: FETCH.
  - BRANCH(10): AluSrcA=1, AluSrcB=0, ALUOp=SUB, PCWriteCond=1, PCSource=1, BranchNe=(opcode==0x05). Next: FETCH.
  - JUMP(11): PCWrite=1, PCSource=2, ALUOp=LOAD. Next: FETCH.
  - EXCEPT(12): see Configuration.
- Wait counter:
  - 4 bits, cleared on entry to FETCH/MEM_READ/MEM_WRITE, increments each cycle in them.
  - "Last cycle" means count==MEM_WAIT. With MEM_WAIT=0 each memory state is a single cycle.

## Timing
- Reset:
  - reset low → state FETCH and counter 0 immediately, asynchronously.
  - While low, all write enables (PCWrite, PCWriteCond, IRWrite, RegWrite, ABWrite, AluOutWrite, MDRWrite, EPCWrite, MemReadWrite) are forced 0. State_out=0; selects take their FETCH values.
  - Reset mid-instruction abandons it; no partial register-file or memory write occurs after reset asserts.
  - First fetch completes MEM_WAIT+1 cycles after reset release.
- Latency in cycles, with W=MEM_WAIT+1:
  - R-type: W+3
  - addi: W+3
  - lw: 2W+3
  - sw: 2W+2
  - beq/bne: W+2
  - j: W+2
- opcode/funct must be stable from DECODE until the instruction returns to FETCH. They are sampled only in DECODE, R_EXEC, MEM_ADDR and BRANCH.

## Configuration
- CTRL_EXCEPTION_EN defined:
  - Undefined instruction: DECODE → EXCEPT → FETCH.
  - EXCEPT: AluSrcA=0, AluSrcB=1, ALUOp=SUB, EPCWrite=1, PCWrite=1, PCSource=3. EPC receives the address of the faulting instruction.
- CTRL_EXCEPTION_EN undefined:
  - Undefined instruction: DECODE → FETCH, executing as a NOP.
  - EXCEPT is unreachable and omitted; EPCWrite is tied 0.

## Structure
- Package control_pkg holds:
  - state_t enum with the encodings above
  - alu_op_t enum
  - opcode and funct localparams
- Sub-module mem_wait_counter (clear, enable, MEM_WAIT compare, `last` output) is instantiated once.
- The FSM is one always_ff for the state plus one always_comb for outputs and next state.

## Test plan
- Reset low mid-MEM_WRITE with MEM_WAIT=2 → MemReadWrite=0 and State_out=0 the same cycle. After release, IRWrite=1 and PCWrite=1 exactly on the 3rd cycle.
- add (opcode 0x00, funct 0x20), MEM_WAIT=2 → state sequence 0,0,0,1,2,3,0. ALUOpOut=ADD in state 2; RegWrite=1, RegDst=1 in state 3 only.
- lw (0x23), MEM_WAIT=3 → MEM_READ lasts 4 cycles, MDRWrite pulses only on its 4th cycle. MEM_WB then has MemtoReg=1, RegWrite=1; total 11 cycles.
- bne (0x05), MEM_WAIT=0 → BRANCH with PCWriteCond=1, BranchNe=1, PCSource=1, ALUOp=SUB; 3 cycles total.
- opcode 0x3F with CTRL_EXCEPTION_EN → State_out 12, EPCWrite=1, PCSource=3, then FETCH. Without the macro: DECODE→FETCH, EPCWrite never 1.
- j (0x02), then sw (0x2B) with MEM_WAIT=1 → JUMP with PCSource=2, PCWrite=1. sw asserts MemReadWrite=1, IorD=1 for exactly 2 cycles.
